serial_eq_cmp: RTL and testbench

- Bit-serial word equality comparator, MSB first; the word-level consumer of the team's 1-bit XNOR equality cell.
- Accepts two N-bit operands through a start/ready handshake and feeds one bit pair per cycle through a single XNOR cell.
- Accumulates the match result and reports equality plus the position of the first differing bit.
- Sits between operand registers and control logic that needs a low-area compare.

---
 rtl/serial_eq_pkg.sv | 16 +
 rtl/serial_eq_cmp_if.sv | 24 ++
 rtl/serial_eq_cmp_bit_eq.sv | 8 +
 rtl/serial_eq_cmp.sv | 112 +++++++++++
 tb/tb_serial_eq_cmp.sv | 143 ++++++++++++++
 5 files changed

// File: rtl/serial_eq_pkg.sv
// Shared types and helpers for the bit-serial equality comparator.
// Optional build macro used by this block: SERIAL_EQ_EARLY_EXIT_EN.
package serial_eq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

  // Width of a bit index into an n-bit word; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_eq_cmp_if.sv
// Start/ready operand handshake and result bus of serial_eq_cmp.
interface serial_eq_cmp_if import serial_eq_pkg::*; #(
  parameter int N     = 8,
  parameter int IDX_W = idx_w(N)
);
  logic             start;
  logic [N-1:0]     a;
  logic [N-1:0]     b;
  logic             ready;
  logic             busy;
  logic             done;
  logic             eq;
  logic [IDX_W-1:0] mismatch_idx;

  modport master (
    output start, a, b,
    input  ready, busy, done, eq, mismatch_idx
  );

  modport slave (
    input  start, a, b,
    output ready, busy, done, eq, mismatch_idx
  );
endinterface

// File: rtl/serial_eq_cmp_bit_eq.sv
// 1-bit XNOR equality cell: s is high when a and b match.
module bit_eq (
  output logic s,
  input  logic a,
  input  logic b
);
  xnor u_xnor (s, a, b);
endmodule

// File: rtl/serial_eq_cmp.sv
// Bit-serial MSB-first word equality comparator built around a single bit_eq cell.
// Define SERIAL_EQ_EARLY_EXIT_EN to finish on the first differing bit.
module serial_eq_cmp import serial_eq_pkg::*; #(
  parameter int N     = 8,
  parameter int IDX_W = idx_w(N)
) (
  input logic            clk,
  input logic            reset,
  serial_eq_cmp_if.slave bus
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  state_e           state_q, state_d;
  logic [N-1:0]     sa_q, sa_d;
  logic [N-1:0]     sb_q, sb_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             acc_q, acc_d;
  logic             found_q, found_d;
  logic             eq_q, eq_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             bit_s;

  bit_eq u_bit_eq (
    .s (bit_s),
    .a (sa_q[N-1]),
    .b (sb_q[N-1])
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      cnt_q   <= '0;
      acc_q   <= 1'b1;
      found_q <= 1'b0;
      eq_q    <= 1'b1;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      found_q <= found_d;
      eq_q    <= eq_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    found_d = found_q;
    eq_d    = eq_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          sa_d    = bus.a;
          sb_d    = bus.b;
          cnt_d   = '0;
          acc_d   = 1'b1;
          found_d = 1'b0;
          eq_d    = 1'b1;
          idx_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        acc_d = acc_q & bit_s;
        // Only the first mismatch seen MSB-first is recorded.
        if (!bit_s && !found_q) begin
          idx_d   = LAST - cnt_q;
          found_d = 1'b1;
        end
        sa_d  = {sa_q[N-2:0], 1'b0};
        sb_d  = {sb_q[N-2:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          eq_d    = acc_q & bit_s;
          cnt_d   = '0;
          state_d = DONE;
        end
`ifdef SERIAL_EQ_EARLY_EXIT_EN
        if (!bit_s) begin
          eq_d    = 1'b0;
          cnt_d   = '0;
          state_d = DONE;
        end
`else
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status flags decode straight from the state flops, so no input reaches an output.
  always_comb begin
    bus.ready        = (state_q == IDLE);
    bus.busy         = (state_q == SHIFT);
    bus.done         = (state_q == DONE);
    bus.eq           = eq_q;
    bus.mismatch_idx = idx_q;
  end

endmodule

// File: tb/tb_serial_eq_cmp.sv
// Directed self-checking bench for serial_eq_cmp; expected timing follows
// SERIAL_EQ_EARLY_EXIT_EN when the bench is built with that macro.
module tb_serial_eq_cmp;
  import serial_eq_pkg::*;

  localparam int N     = 8;
  localparam int IDX_W = idx_w(N);
`ifdef SERIAL_EQ_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  int   lat;
  int   doneSeen;

  serial_eq_cmp_if #(.N(N), .IDX_W(IDX_W)) bus ();

  serial_eq_cmp #(.N(N), .IDX_W(IDX_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Cycles from the accepting edge until done is seen high.
  function automatic int latFor(input logic e, input int idx);
    return (e || !EARLY) ? N : N - idx;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic [N-1:0] av, input logic [N-1:0] bv);
    bus.start = s;
    bus.a     = av;
    bus.b     = bv;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkStatus(input string tag, input logic r, input logic bz, input logic d,
                             input logic e, input logic [IDX_W-1:0] i);
    checkOutput(tag, 32'({bus.ready, bus.busy, bus.done, bus.eq, bus.mismatch_idx}),
                32'({r, bz, d, e, i}));
  endtask

  // Ticks until done is high; optionally rewrites operand A at tick changeAt.
  task automatic waitDone(input int changeAt, input logic [N-1:0] newA, output int cycles);
    cycles = -1;
    for (int c = 1; c <= 4 * N; c++) begin
      if (c == changeAt) bus.a = newA;
      tick();
      if (bus.done) begin
        cycles = c;
        break;
      end
    end
  endtask

  task automatic runCompare(input string tag, input logic [N-1:0] av, input logic [N-1:0] bv,
                            input int changeAt, input logic [N-1:0] newA,
                            input logic expEq, input logic [IDX_W-1:0] expIdx);
    int l;
    applyStimulus(1'b1, av, bv);
    tick();
    applyStimulus(1'b0, av, bv);
    checkStatus({tag, "_accept"}, 1'b0, 1'b1, 1'b0, 1'b1, '0);
    waitDone(changeAt, newA, l);
    checkOutput({tag, "_latency"}, 32'(l), 32'(latFor(expEq, int'(expIdx))));
    checkStatus({tag, "_done"}, 1'b0, 1'b0, 1'b1, expEq, expIdx);
    tick();
    checkStatus({tag, "_held"}, 1'b1, 1'b0, 1'b0, expEq, expIdx);
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, '0, '0);
    repeat (3) tick();
    checkStatus("reset_state", 1'b1, 1'b0, 1'b0, 1'b1, '0);
    reset = 1'b0;

    doneSeen = 0;
    repeat (5) begin
      tick();
      if (bus.done) doneSeen++;
    end
    checkOutput("idle_no_done", 32'(doneSeen), 32'd0);
    checkStatus("idle_state", 1'b1, 1'b0, 1'b0, 1'b1, '0);

    runCompare("equal_a5", 8'hA5, 8'hA5, 0, '0, 1'b1, 3'd0);
    runCompare("lsb_diff", 8'hA5, 8'hA4, 0, '0, 1'b0, 3'd0);
    runCompare("msb_diff", 8'h80, 8'h00, 0, '0, 1'b0, 3'd7);
    runCompare("multi_diff", 8'h3C, 8'h18, 3, 8'h18, 1'b0, 3'd5);

    applyStimulus(1'b1, 8'h5A, 8'h5A);
    tick();
    applyStimulus(1'b0, 8'h5A, 8'h5A);
    repeat (3) tick();
    checkStatus("mid_shift", 1'b0, 1'b1, 1'b0, 1'b1, '0);
    #2 reset = 1'b1;
    #1 checkStatus("async_reset", 1'b1, 1'b0, 1'b0, 1'b1, '0);
    tick();
    reset = 1'b0;
    doneSeen = 0;
    repeat (N + 4) begin
      tick();
      if (bus.done) doneSeen++;
    end
    checkOutput("abandon_no_done", 32'(doneSeen), 32'd0);
    checkStatus("after_abandon", 1'b1, 1'b0, 1'b0, 1'b1, '0);

    applyStimulus(1'b1, 8'h00, 8'h00);
    tick();
    applyStimulus(1'b1, 8'hFF, 8'h7F);
    waitDone(0, '0, lat);
    checkOutput("b2b_first_latency", 32'(lat), 32'(latFor(1'b1, 0)));
    checkStatus("b2b_first_done", 1'b0, 1'b0, 1'b1, 1'b1, 3'd0);
    waitDone(0, '0, lat);
    checkOutput("b2b_second_gap", 32'(lat), 32'(2 + latFor(1'b0, 7)));
    checkStatus("b2b_second_done", 1'b0, 1'b0, 1'b1, 1'b0, 3'd7);
    applyStimulus(1'b0, '0, '0);
    tick();
    checkStatus("b2b_idle", 1'b1, 1'b0, 1'b0, 1'b0, 3'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
